warmboot_sequencer: RTL
=======================

// Module: warmboot_sequencer
// PURPOSE
// Sequences the iCE40 SB_WARMBOOT primitive on behalf of tinyfpga_bootloader.
// On a boot request it drains in-flight SPI/USB activity and detaches from USB by
// dropping the D+ pull-up. It then drives S1/S0 stable and pulses BOOT into the
// selected image. Sits between the bootloader core and the board-level SB_WARMBOOT
// and pin_pu.
// PARAMETERS
// DRAIN_TIMEOUT  48000  max cycles waiting for spi_busy/usb_tx_en low (1 ms @48MHz)
// DETACH_CYCLES  480000 cycles pull-up held low before boot (10 ms @48MHz)
// SETTLE_CYCLES  16     cycles S1/S0 held stable before wb_boot rises
// PORTS
// clk_48mhz     in   1  sole clock
// reset         in   1  synchronous, active-high
// boot_req      in   1  single-cycle request; sampled only in IDLE
// boot_image    in   2  image select {S1,S0}; latched with accepted boot_req
// spi_busy      in   1  flash SPI transaction in progress
// usb_tx_en     in   1  USB PHY currently transmitting
// usb_pu        out  1  D+ pull-up enable (drives pin_pu)
// wb_s1         out  1  to SB_WARMBOOT.S1
// wb_s0         out  1  to SB_WARMBOOT.S0
// wb_boot       out  1  to SB_WARMBOOT.BOOT
// busy          out  1  sequence in progress (state != IDLE)
// drain_timeout out  1  sticky: DRAIN exited by timeout, not by idle bus
// BEHAVIOUR
// - Reset values: usb_pu=1, wb_s1=0, wb_s0=0, wb_boot=0, busy=0,
//   drain_timeout=0, state=IDLE, counter=0, latched image=2'b00.
// - All outputs are registered; none is combinational from inputs.
// - Counter width is $clog2(max(DRAIN_TIMEOUT,DETACH_CYCLES,SETTLE_CYCLES)+1).
// - The counter clears on every state change.
// - IDLE:
//   - boot_req=1 latches boot_image, clears counter, goes to DRAIN.
//   - busy=1 from the next cycle.
// - DRAIN:
//   - Counter increments each cycle.
//   - spi_busy=0 and usb_tx_en=0 in the same cycle -> DETACH.
//   - Else counter==DRAIN_TIMEOUT-1 -> DETACH and drain_timeout<=1.
//   - If both conditions hold in one cycle, the idle bus wins and drain_timeout stays 0.
// - DETACH:
//   - usb_pu=0 from the first DETACH cycle and stays 0 until reset.
//   - wb_s1/wb_s0 are driven from the latched image from entry into DETACH.
//   - Exits to SETTLE after exactly DETACH_CYCLES cycles in DETACH.
// - SETTLE: holds S1/S0; after SETTLE_CYCLES cycles -> BOOT.
// - BOOT:
//   - wb_boot=1 and is held until reset (the device reconfigures).
//   - BOOT is terminal; further boot_req is ignored.
// - boot_req while busy=1 is ignored, and the latched image is not changed.
// - boot_image changes after acceptance have no effect.
// - Reset asserted mid-sequence (any state) returns all outputs to reset values
//   on the next edge. usb_pu re-asserts immediately.
// - Latency for an idle bus: boot_req at cycle 0 -> DRAIN at 1 -> DETACH at 2 ->
//   wb_boot rises at cycle 2+DETACH_CYCLES+SETTLE_CYCLES.
// TESTING (bench overrides DRAIN_TIMEOUT=8, DETACH_CYCLES=20, SETTLE_CYCLES=4)
// 1 Idle bus, boot_req with image=2'b01 at cyc0:
//   usb_pu falls at cyc2; S1/S0=0/1 from cyc2; wb_boot rises at cyc26; drain_timeout=0.
// 2 spi_busy high until cyc5, image=2'b10:
//   DETACH entered at cyc6; wb_boot at cyc30; S1/S0=1/0.
// 3 spi_busy stuck high: DRAIN exits after 8 cycles; drain_timeout=1; boot still completes.
// 4 Second boot_req with image=2'b11 during DETACH: ignored; S1/S0 keep the first image.
// 5 Reset pulsed during SETTLE: next cycle usb_pu=1, wb_*=0, busy=0;
//   a fresh boot_req then runs a full sequence.
// 6 spi_busy falls on the same cycle the timeout counter expires: drain_timeout stays 0.

Source files
------------

// File: rtl/warmboot_sequencer.sv
// Sequences SB_WARMBOOT: drain SPI/USB traffic, detach from USB, settle S1/S0, then pulse BOOT.
// All outputs are registered from the next-state logic so none is combinational from inputs.
module warmboot_sequencer #(
    parameter int DRAIN_TIMEOUT = 48000,
    parameter int DETACH_CYCLES = 480000,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic       clk_48mhz,
    input  logic       reset,
    input  logic       boot_req,
    input  logic [1:0] boot_image,
    input  logic       spi_busy,
    input  logic       usb_tx_en,
    output logic       usb_pu,
    output logic       wb_s1,
    output logic       wb_s0,
    output logic       wb_boot,
    output logic       busy,
    output logic       drain_timeout
);

    localparam int MAX_A      = (DRAIN_TIMEOUT > DETACH_CYCLES) ? DRAIN_TIMEOUT : DETACH_CYCLES;
    localparam int MAX_CYCLES = (MAX_A > SETTLE_CYCLES) ? MAX_A : SETTLE_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [CW-1:0] DRAIN_LAST  = CW'(DRAIN_TIMEOUT - 1);
    localparam logic [CW-1:0] DETACH_LAST = CW'(DETACH_CYCLES - 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        DETACH,
        SETTLE,
        BOOT
    } state_t;

    state_t        state, state_next;
    logic [CW-1:0] count, count_next;
    logic [1:0]    image, image_next;
    logic          timeout_next;
    logic          detached_next;

    always_comb begin
        state_next   = state;
        count_next   = count + 1'b1;
        image_next   = image;
        timeout_next = drain_timeout;
        case (state)
            IDLE: begin
                count_next = '0;
                if (boot_req) begin
                    image_next = boot_image;
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                // An idle bus takes priority over a coincident timeout.
                if (!spi_busy && !usb_tx_en) begin
                    state_next = DETACH;
                end else if (count == DRAIN_LAST) begin
                    state_next   = DETACH;
                    timeout_next = 1'b1;
                end
            end
            DETACH: begin
                if (count == DETACH_LAST) state_next = SETTLE;
            end
            SETTLE: begin
                if (count == SETTLE_LAST) state_next = BOOT;
            end
            BOOT: begin
                count_next = '0;
            end
            default: begin
                state_next = IDLE;
                count_next = '0;
            end
        endcase
        if (state_next != state) count_next = '0;
        detached_next = (state_next == DETACH) || (state_next == SETTLE) || (state_next == BOOT);
    end

    // Outputs follow state_next so they change on the same edge as the state itself.
    always_ff @(posedge clk_48mhz) begin
        if (reset) begin
            state         <= IDLE;
            count         <= '0;
            image         <= 2'b00;
            usb_pu        <= 1'b1;
            wb_s1         <= 1'b0;
            wb_s0         <= 1'b0;
            wb_boot       <= 1'b0;
            busy          <= 1'b0;
            drain_timeout <= 1'b0;
        end else begin
            state         <= state_next;
            count         <= count_next;
            image         <= image_next;
            usb_pu        <= !detached_next;
            wb_s1         <= detached_next & image_next[1];
            wb_s0         <= detached_next & image_next[0];
            wb_boot       <= (state_next == BOOT);
            busy          <= (state_next != IDLE);
            drain_timeout <= timeout_next;
        end
    end

endmodule
